// File: rtl/filt_word_fetch.sv
// filt_word_fetch: turns the address counter's output into single-cycle reads
// from a synchronous word memory. Returned words are buffered in a small FIFO
// that feeds the 1x1 filter accelerator. Credit-based flow control pauses the
// counter so the FIFO can never overflow.
module filt_word_fetch #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [31:0]       cnt_count,
  input  logic              cnt_done,
  output logic              cnt_pause,
  output logic              mem_rd,
  output logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              file_done
);

  localparam int                 PTR_W     = $clog2(DEPTH);
  localparam logic [31:0]        IDLE_ADDR = 32'hFFFF_FFFF;
  localparam logic [PTR_W-1:0]   PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]     CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]     CNT_FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W+1:0]   OCC_DEPTH = (PTR_W+2)'(DEPTH);
  localparam logic [PTR_W+1:0]   OCC_PAUSE = (PTR_W+2)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t             state, state_next;
  logic [31:0]        last_addr;
  logic [1:0]         inflight;    // reads issued whose data has not been pushed yet
  logic               rvalid;      // mem_rdata carries a returned word this cycle
  logic [DATA_W-1:0]  fifo_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     fifo_count;
  logic [PTR_W+1:0]   occ;
  logic               active, new_addr, issue, flush, push, pop;

  // Datapath control derived from current state and inputs.
  assign active   = (state == FETCH) || (state == DRAIN);
  assign occ      = (PTR_W+2)'(fifo_count) + (PTR_W+2)'(inflight);
  assign new_addr = (cnt_count != last_addr) && (cnt_count != IDLE_ADDR);
  assign issue    = (state == FETCH) && start && new_addr && (occ < OCC_DEPTH);
  // Any move to IDLE (abort or end of file) empties the FIFO; late data is dropped.
  assign flush    = (state_next == IDLE);
  assign push     = rvalid && active && !flush;
  assign pop      = out_valid && out_ready && !flush;

  // State register.
  // NOTE: sequential state is updated with non-blocking (<=) assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic and the state-decoded outputs.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_data   = '0;
    out_last   = 1'b0;
    cnt_pause  = 1'b0;
    file_done  = 1'b0;

    case (state)
      IDLE:    if (start && inflight == 2'd0) state_next = FETCH;
      FETCH: begin
        if (!start)                      state_next = IDLE;
        else if (cnt_done && !new_addr)  state_next = DRAIN;
      end
      DRAIN: begin
        if (!start)                                       state_next = IDLE;
        else if (fifo_count == '0 && inflight == 2'd0)    state_next = DONE;
      end
      DONE:    if (!start) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    out_valid = active && (fifo_count != '0);
    if (out_valid) out_data = fifo_mem[rd_ptr];
    out_last  = (state == DRAIN) && out_valid && (fifo_count == CNT_ONE) && (inflight == 2'd0);
    cnt_pause = (state == FETCH) && (occ >= OCC_PAUSE);
    file_done = (state == DONE);
  end

  // Read issue, address tracking and in-flight bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      last_addr <= IDLE_ADDR;
      rvalid    <= 1'b0;
      inflight  <= 2'd0;
    end else begin
      mem_rd <= issue;
      rvalid <= mem_rd;
      if (issue) mem_addr <= cnt_count;

      if (state == IDLE) last_addr <= IDLE_ADDR;
      else if (issue)    last_addr <= cnt_count;

      // Returning data retires a read even when it is discarded after an abort.
      case ({issue, rvalid})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  // FIFO pointers and occupancy; a push and pop together leave the count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage write port.
  // NOTE: the storage array is intentionally not reset; the pointers and
  // count define which entries are valid, and out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  // Credit accounting must make these unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && fifo_count == CNT_FULL))
    else $error("filt_word_fetch: fifo overflow");

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && fifo_count == '0))
    else $error("filt_word_fetch: fifo underflow");

endmodule

// File: tb/tb_filt_word_fetch.sv
// Testbench for filt_word_fetch: models the address counter and the memory,
// and checks the output stream against the file's expected word sequence.
module tb_filt_word_fetch;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [31:0]       cnt_count;
  logic              cnt_done;
  logic              cnt_pause;
  logic              mem_rd;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              file_done;

  filt_word_fetch #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cnt_count (cnt_count),
    .cnt_done  (cnt_done),
    .cnt_pause (cnt_pause),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .file_done (file_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // file / model state
  int          filesize  = 0;
  logic [31:0] data_key  = '0;
  int          ready_pct = 100;
  logic        mon_on    = 1'b0;
  int          exp_addr, rd_count, delivered, occ, valid_count, last_count, last_at;
  logic [31:0] addr_log [64];
  logic [31:0] word_log [64];
  logic        tick;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // memory content: word at address a is 2*a xor a per-file key
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'd2) ^ data_key;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Address counter: advances every second enabled cycle; pause stops the
  // next advance (it reacts one cycle late, like a registered counter).
  always @(posedge clk or negedge rst_n) begin
    logic [31:0] nxt;
    if (!rst_n) begin
      cnt_count <= 32'hFFFF_FFFF; cnt_done <= 1'b0; tick <= 1'b0;
    end else if (!start) begin
      cnt_count <= 32'hFFFF_FFFF; cnt_done <= 1'b0; tick <= 1'b0;
    end else if (filesize == 0) begin
      cnt_done <= 1'b1;
    end else if (!cnt_done) begin
      nxt = cnt_count + 32'd1;
      if (tick) begin
        cnt_count <= nxt;
        cnt_done  <= (nxt == 32'(filesize - 1));
        tick      <= 1'b0;
      end else if (!cnt_pause) begin
        tick <= 1'b1;
      end
    end
  end

  // Synchronous memory: data valid exactly one cycle after mem_rd, junk otherwise.
  always @(posedge clk) mem_rdata <= mem_rd ? word_of(mem_addr) : $urandom();

  // Accelerator ready, changed just after each rising edge.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Every-cycle compare against the file model: k-th read is address k, k-th
  // delivered word is word_of(k), only the final word is marked last.
  always @(negedge clk) begin
    if (mon_on && rst_n) begin
      if (mem_rd) begin
        check("mem_addr", mem_addr, 64'(exp_addr));
        check("rd_in_file", 64'(exp_addr < filesize), 64'd1);
        if (rd_count < 64) addr_log[rd_count] = mem_addr;
        exp_addr++; rd_count++; occ++;
      end
      check("occ_le_depth", 64'(occ <= DEPTH), 64'd1);
      if (cnt_pause) check("pause_needs_occ", 64'(occ >= DEPTH - 1), 64'd1);
      if (out_valid) begin
        valid_count++;
        check("word_in_file", 64'(delivered < filesize), 64'd1);
        check("out_data", out_data, 64'(word_of(32'(delivered))));
        check("out_last", out_last, 64'(delivered == filesize - 1));
        if (out_ready) begin
          if (delivered < 64) word_log[delivered] = out_data;
          if (out_last) begin last_count++; last_at = delivered; end
          delivered++; occ--;
        end
      end else begin
        check("last_without_valid", out_last, 64'd0);
      end
      if (file_done) check("done_all_delivered", 64'(delivered), 64'(filesize));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic new_file(input int n, input logic [31:0] key);
    filesize = n; data_key = key;
    exp_addr = 0; rd_count = 0; delivered = 0; occ = 0;
    valid_count = 0; last_count = 0; last_at = -1;
  endtask

  task automatic run_to_done(input int max, output int cycles);
    cycles = 0;
    while (!file_done && cycles < max) begin cyc(1); cycles++; end
    check("file_done_reached", file_done, 64'd1);
  endtask

  task automatic end_file();
    start = 1'b0;
    cyc(1);
    check("done_drops_with_start", file_done, 64'd0);
    cyc(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_rd"},    mem_rd,    64'd0);
    check({tag, "_mem_addr"},  mem_addr,  64'd0);
    check({tag, "_cnt_pause"}, cnt_pause, 64'd0);
    check({tag, "_out_valid"}, out_valid, 64'd0);
    check({tag, "_out_last"},  out_last,  64'd0);
    check({tag, "_file_done"}, file_done, 64'd0);
    check({tag, "_out_data"},  out_data,  64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc_n, vcount, n;
    rst_n = 1'b0; start = 1'b0;
    new_file(0, '0);
    cyc(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc(3);
    check("idle_no_rd", mem_rd, 64'd0);
    mon_on = 1'b1;

    // 4-word file, memory returns 2*addr, accelerator always ready
    new_file(4, 32'h0); ready_pct = 100; start = 1'b1;
    run_to_done(14, cyc_n);
    for (int i = 0; i < 4; i++) check("t4_addr", addr_log[i], 64'(i));
    check("t4_w0", word_log[0], 64'd0);
    check("t4_w1", word_log[1], 64'd2);
    check("t4_w2", word_log[2], 64'd4);
    check("t4_w3", word_log[3], 64'd6);
    check("t4_last_count", 64'(last_count), 64'd1);
    check("t4_last_at", 64'(last_at), 64'd3);
    cyc(5);
    check("t4_done_held", file_done, 64'd1);
    end_file();

    // throughput: 16 words at one word per two cycles
    new_file(16, 32'h0000_7000); ready_pct = 100; start = 1'b1;
    run_to_done(38, cyc_n);
    check("t16_delivered", 64'(delivered), 64'd16);
    end_file();

    // 8-word file with a stalled accelerator: credit limits reads to DEPTH
    new_file(8, 32'h0000_0100); ready_pct = 0; start = 1'b1;
    cyc(30);
    check("stall_rd_count", 64'(rd_count), 64'd4);
    check("stall_pause", cnt_pause, 64'd1);
    check("stall_valid", out_valid, 64'd1);
    check("stall_head", out_data, 64'h100);
    ready_pct = 100;
    run_to_done(200, cyc_n);
    check("stall_delivered", 64'(delivered), 64'd8);
    check("stall_w7", word_log[7], 64'h10E);
    end_file();

    // empty file
    new_file(0, 32'h0); ready_pct = 100; start = 1'b1;
    run_to_done(3, cyc_n);
    check("empty_rd", 64'(rd_count), 64'd0);
    check("empty_valid", 64'(valid_count), 64'd0);
    end_file();

    // single-word file
    new_file(1, 32'h5A5A_0000); ready_pct = 100; start = 1'b1;
    run_to_done(20, cyc_n);
    check("one_rd", 64'(rd_count), 64'd1);
    check("one_addr", addr_log[0], 64'd0);
    check("one_word", word_log[0], 64'h5A5A_0000);
    check("one_last", 64'(last_count), 64'd1);
    end_file();

    // abort with three reads issued and the third still in flight
    new_file(8, 32'h0300_0000); ready_pct = 0; start = 1'b1;
    n = 0;
    while (rd_count < 3 && n < 50) begin cyc(1); n++; end
    check("abort_rd_count", 64'(rd_count), 64'd3);
    check("abort_inflight", mem_rd, 64'd1);
    start = 1'b0;
    vcount = valid_count;
    cyc(1);
    check("abort_valid", out_valid, 64'd0);
    check("abort_last", out_last, 64'd0);
    check("abort_done", file_done, 64'd0);
    cyc(4);
    check("abort_no_late_word", 64'(valid_count), 64'(vcount));
    new_file(6, 32'h0000_0055); ready_pct = 100; start = 1'b1;
    run_to_done(60, cyc_n);
    check("restart_addr0", addr_log[0], 64'd0);
    check("restart_delivered", 64'(delivered), 64'd6);
    end_file();

    // asynchronous reset between edges in the middle of a stalled transfer
    new_file(8, 32'h0000_0A00); ready_pct = 0; start = 1'b1;
    cyc(30);
    check("pre_rst_valid", out_valid, 64'd1);
    check("pre_rst_pause", cnt_pause, 64'd1);
    check("pre_rst_addr", mem_addr, 64'd3);
    mon_on = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    start = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(4);
    check("post_rst_valid", out_valid, 64'd0);
    check("post_rst_rd", mem_rd, 64'd0);
    check("post_rst_done", file_done, 64'd0);
    new_file(5, 32'h0000_0B00); ready_pct = 60; mon_on = 1'b1; start = 1'b1;
    run_to_done(200, cyc_n);
    check("post_rst_delivered", 64'(delivered), 64'd5);
    end_file();

    // randomized files: size, contents and accelerator backpressure
    for (int f = 0; f < 10; f++) begin
      new_file($urandom_range(1, 12), $urandom());
      case ($urandom_range(2))
        0:       ready_pct = 100;
        1:       ready_pct = 60;
        default: ready_pct = 25;
      endcase
      start = 1'b1;
      run_to_done(400, cyc_n);
      check("rand_delivered", 64'(delivered), 64'(filesize));
      check("rand_last_once", 64'(last_count), 64'd1);
      end_file();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
